// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the 2-way, 64-set cache lookup/fill path.
//   - address field positions (tag, set index, word offset)
//   - metadata bit positions within one way's byte {valid, lru, tag[5:0]}
//   - way numbering in the 2-bit per-way strobes
//   - controller state enum and a tag-compare helper
package cache_pkg;

    localparam int TAG_W = 6;
    localparam int SET_W = 6;
    localparam int WORDS = 8;
    localparam int OFF_W = 3;
    localparam int SETS  = 2 ** SET_W;

    // Request address fields
    localparam int TAG_HI = 15;
    localparam int TAG_LO = 10;
    localparam int IDX_HI = 9;
    localparam int IDX_LO = 4;
    localparam int OFF_HI = 3;
    localparam int OFF_LO = 1;

    // Metadata byte layout per way
    localparam int VALID_B = 7;
    localparam int LRU_B   = 6;
    localparam int TAG_LSB = 0;

    // Way positions in meta_hit / meta_write / data_we
    localparam int WAY_A = 1;
    localparam int WAY_B = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        INSTALL = 2'd2
    } state_t;

    function automatic logic way_hit(input logic [7:0] meta, input logic [TAG_W-1:0] tag);
        return meta[VALID_B] && (meta[TAG_LSB +: TAG_W] == tag);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: issue and return bookkeeping for one 8-word block fill.
//   clk, rst_n      clock, async active-low reset
//   active          controller is in FILL
//   mem_data_valid  memory return strobe
//   issue_cnt       word offset of the next read request
//   ret_cnt         word offset of the next expected return
//   issue_req       a read request goes out this cycle
//   ret_accept      the return this cycle is accepted (its request was already issued)
//   done            the 8th return is being accepted
module fill_counter
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             mem_data_valid,
    output logic [OFF_W-1:0] issue_cnt,
    output logic [OFF_W-1:0] ret_cnt,
    output logic             issue_req,
    output logic             ret_accept,
    output logic             done
);

    // Set once offset 7 has been issued; issue_cnt then holds instead of wrapping.
    logic issue_full_q;

    assign issue_req  = active && !issue_full_q;
    // A return is only legal once its request went out on an earlier cycle.
    assign ret_accept = active && mem_data_valid && (issue_full_q || (ret_cnt < issue_cnt));
    assign done       = ret_accept && (ret_cnt == OFF_W'(WORDS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            issue_full_q <= 1'b0;
        end else if (done) begin
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            issue_full_q <= 1'b0;
        end else begin
            if (issue_req) begin
                if (issue_cnt == OFF_W'(WORDS - 1)) issue_full_q <= 1'b1;
                else                                issue_cnt    <= issue_cnt + 1'b1;
            end
            if (ret_accept) ret_cnt <= ret_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: lookup and miss-fill controller for the 2-way, 64-set cache.
//   req_valid/req_addr   access request (held by the requester while stall=1)
//   meta_rd              metadata of addressed set: [15:8] way A, [7:0] way B
//   set_en               one-hot set enable (request index, or latched index during a fill)
//   meta_hit/meta_write  per-way hit strobe / metadata write strobe ({A,B})
//   meta_din             metadata byte installed after a fill
//   mem_rd_req/mem_addr  word read requests for the missing block
//   mem_data_valid/mem_data  in-order memory returns
//   data_we/data_word_en/data_wr  data-array write of each returned word
//   stall                pipeline hold
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    input  logic [15:0] meta_rd,
    output logic [63:0] set_en,
    output logic [1:0]  meta_hit,
    output logic [1:0]  meta_write,
    output logic [7:0]  meta_din,
    output logic        mem_rd_req,
    output logic [15:0] mem_addr,
    input  logic        mem_data_valid,
    input  logic [15:0] mem_data,
    output logic [1:0]  data_we,
    output logic [7:0]  data_word_en,
    output logic [15:0] data_wr,
    output logic        stall
);

    localparam logic [1:0] WAY_A_OH = 2'(1 << WAY_A);
    localparam logic [1:0] WAY_B_OH = 2'(1 << WAY_B);

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_q;
    logic [SET_W-1:0] idx_q;
    logic             victim_a_q;

    logic [TAG_W-1:0] req_tag;
    logic [SET_W-1:0] req_idx;
    logic [7:0]       meta_a, meta_b;
    logic             hit_a, hit_b, victim_a;
    logic [1:0]       victim_oh;

    logic [OFF_W-1:0] issue_cnt, ret_cnt;
    logic             issue_req, ret_accept, fill_done;

    assign req_tag   = req_addr[TAG_HI:TAG_LO];
    assign req_idx   = req_addr[IDX_HI:IDX_LO];
    assign meta_a    = meta_rd[15:8];
    assign meta_b    = meta_rd[7:0];
    assign hit_a     = way_hit(meta_a, req_tag);
    assign hit_b     = way_hit(meta_b, req_tag);
    assign victim_oh = victim_a_q ? WAY_A_OH : WAY_B_OH;

    // Victim: invalid way first (A before B), then the way with lru=0; A on ties.
    always_comb begin
        if      (!meta_a[VALID_B]) victim_a = 1'b1;
        else if (!meta_b[VALID_B]) victim_a = 1'b0;
        else if (!meta_a[LRU_B])   victim_a = 1'b1;
        else if (!meta_b[LRU_B])   victim_a = 1'b0;
        else                       victim_a = 1'b1;
    end

    fill_counter u_fill_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .active         (state_q == FILL),
        .mem_data_valid (mem_data_valid),
        .issue_cnt      (issue_cnt),
        .ret_cnt        (ret_cnt),
        .issue_req      (issue_req),
        .ret_accept     (ret_accept),
        .done           (fill_done)
    );

    // NOTE: the miss latches are reset as well, although they are only read
    // outside IDLE, so no X ever reaches mem_addr or meta_din.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            victim_a_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid && !hit_a && !hit_b) begin
                tag_q      <= req_tag;
                idx_q      <= req_idx;
                victim_a_q <= victim_a;
            end
        end
    end

    // NOTE: every output and state_d gets a default before the case so no
    // path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        set_en       = 64'd1 << req_idx;
        meta_hit     = 2'b00;
        meta_write   = 2'b00;
        meta_din     = 8'h00;
        mem_rd_req   = 1'b0;
        mem_addr     = 16'h0000;
        data_we      = 2'b00;
        data_word_en = 8'h00;
        data_wr      = 16'h0000;
        stall        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (hit_a)      meta_hit = WAY_A_OH;
                    else if (hit_b) meta_hit = WAY_B_OH;
                    else begin
                        stall   = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall      = 1'b1;
                set_en     = 64'd1 << idx_q;
                mem_rd_req = issue_req;
                if (issue_req) mem_addr = {tag_q, idx_q, issue_cnt, 1'b0};
                if (ret_accept) begin
                    data_we      = victim_oh;
                    data_word_en = 8'd1 << ret_cnt;
                    data_wr      = mem_data;
                end
                if (fill_done) state_d = INSTALL;
            end
            INSTALL: begin
                stall      = 1'b1;
                set_en     = 64'd1 << idx_q;
                meta_write = victim_oh;
                meta_din   = {1'b1, 1'b1, tag_q};
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl. Stimulus tasks push expected strobes into
// queues; a negedge monitor pops and compares whenever the DUT asserts one.
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic [15:0] meta_rd;
    logic [63:0] set_en;
    logic [1:0]  meta_hit;
    logic [1:0]  meta_write;
    logic [7:0]  meta_din;
    logic        mem_rd_req;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic [1:0]  data_we;
    logic [7:0]  data_word_en;
    logic [15:0] data_wr;
    logic        stall;

    int errors = 0;
    int checks = 0;

    logic [15:0] q_addr[$];
    logic [25:0] q_data[$];   // {data_we, data_word_en, data_wr}
    logic [9:0]  q_meta[$];   // {meta_write, meta_din}
    logic [1:0]  q_hit[$];

    cache_fill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .meta_rd        (meta_rd),
        .set_en         (set_en),
        .meta_hit       (meta_hit),
        .meta_write     (meta_write),
        .meta_din       (meta_din),
        .mem_rd_req     (mem_rd_req),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .data_we        (data_we),
        .data_word_en   (data_word_en),
        .data_wr        (data_wr),
        .stall          (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected no strobe", name, act);
    endtask

    // Monitor: every asserted strobe must match the head of its queue.
    always @(negedge clk) begin
        if (meta_hit != 2'b00 && meta_write != 2'b00)
            unexpected("hit_and_write", {meta_hit, meta_write});
        if (mem_rd_req) begin
            if (q_addr.size() == 0) unexpected("mem_addr_extra", mem_addr);
            else check("mem_addr", mem_addr, q_addr.pop_front());
        end
        if (data_we != 2'b00) begin
            if (q_data.size() == 0) unexpected("data_write_extra", {data_we, data_word_en, data_wr});
            else check("data_write", {data_we, data_word_en, data_wr}, q_data.pop_front());
        end
        if (meta_write != 2'b00) begin
            if (q_meta.size() == 0) unexpected("meta_write_extra", {meta_write, meta_din});
            else check("meta_write", {meta_write, meta_din}, q_meta.pop_front());
        end
        if (meta_hit != 2'b00) begin
            if (q_hit.size() == 0) unexpected("meta_hit_extra", meta_hit);
            else check("meta_hit", meta_hit, q_hit.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check(name, {stall, meta_hit, meta_write, meta_din, mem_rd_req, mem_addr,
                     data_we, data_word_en, data_wr}, 64'd0);
    endtask

    // Miss + fill. gapped: an early (illegal) return pulse in the first FILL
    // cycle, returns every 3rd cycle, then a burst once all 8 are issued.
    // abort_after < 8: reset is asserted right after that many returns.
    task automatic run_fill(input logic [15:0] addr, input logic [15:0] meta, input logic vic_a,
                            input bit gapped, input int abort_after, input logic [15:0] base);
        logic [5:0]  tag;
        logic [5:0]  idx;
        logic [1:0]  vic_oh;
        int          n_addr, n_data, n, cyc;
        bit          v;
        tag    = addr[15:10];
        idx    = addr[9:4];
        vic_oh = vic_a ? 2'b10 : 2'b01;
        n_data = (abort_after < 8) ? abort_after : 8;
        n_addr = (abort_after < 8) ? abort_after + 1 : 8;
        for (int k = 0; k < n_addr; k++) q_addr.push_back({tag, idx, 3'(k), 1'b0});
        for (int k = 0; k < n_data; k++)
            q_data.push_back({vic_oh, 8'(8'd1 << k), 16'(base + 16'(k))});
        if (abort_after >= 8) q_meta.push_back({vic_oh, 2'b11, tag});

        req_valid = 1'b1;
        req_addr  = addr;
        meta_rd   = meta;
        @(negedge clk);
        check("miss_stall", stall, 1'b1);
        check("miss_set_en", set_en, 64'd1 << idx);
        step();
        req_valid      = 1'b0;
        req_addr       = 16'hFFFF;
        meta_rd        = 16'hFFFF;
        mem_data_valid = gapped;
        mem_data       = 16'hDEAD;
        @(negedge clk);
        check("fill_stall", stall, 1'b1);
        check("fill_set_en", set_en, 64'd1 << idx);

        n   = 0;
        cyc = 1;
        while (n < n_data && cyc < 40) begin
            step();
            cyc++;
            v = !gapped || cyc >= 10 || (cyc % 3 == 2);
            mem_data_valid = v;
            mem_data       = v ? 16'(base + 16'(n)) : 16'hBEEF;
            if (v) n++;
        end
        check("returns_driven", n, n_data);

        if (abort_after < 8) begin
            step();
            rst_n          = 1'b0;
            mem_data_valid = 1'b1;
            mem_data       = 16'hBAD0;
            #1;
            check_quiet("reset_outputs");
            check("reset_set_en", set_en, 64'd1 << 63);
            step();
            step();
            rst_n = 1'b1;
            repeat (3) step();
            mem_data_valid = 1'b0;
        end else begin
            step();
            mem_data_valid = 1'b0;
            @(negedge clk);
            check("install_stall", stall, 1'b1);
            check("install_set_en", set_en, 64'd1 << idx);
            step();
            @(negedge clk);
            check("post_install_stall", stall, 1'b0);
            step();
        end
    endtask

    task automatic do_hit(input logic [15:0] addr, input logic [15:0] meta, input logic [1:0] exp_hit);
        q_hit.push_back(exp_hit);
        req_valid = 1'b1;
        req_addr  = addr;
        meta_rd   = meta;
        @(negedge clk);
        check("hit_stall", stall, 1'b0);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = 16'h0C40;
        meta_rd        = 16'h0000;
        mem_data_valid = 1'b0;
        mem_data       = 16'h0000;
        #2;
        check_quiet("por_outputs");
        check("por_set_en", set_en, 64'd1 << 4);
        step();
        rst_n = 1'b1;
        step();

        run_fill(16'h0C40, 16'h0000, 1'b1, 1'b0, 8, 16'hA000);  // cold miss, victim A
        do_hit(16'h0C40, 16'hC300, 2'b10);                       // way A hit
        do_hit(16'h0C40, 16'hC3C3, 2'b10);                       // both match, A wins
        do_hit(16'h0C40, 16'h0083, 2'b01);                       // way B hit
        @(negedge clk);
        check("idle_stall", stall, 1'b0);
        step();
        run_fill(16'h1C50, 16'hC285, 1'b0, 1'b0, 8, 16'hB000);  // lru picks B
        run_fill(16'h0C80, 16'h4385, 1'b1, 1'b0, 8, 16'hC000);  // invalid A tag match is a miss
        run_fill(16'h1C90, 16'hC0C1, 1'b1, 1'b0, 8, 16'h1000);  // both lru=1 -> A
        run_fill(16'h2A30, 16'h8000, 1'b0, 1'b1, 8, 16'hE000);  // gapped returns, victim B
        run_fill(16'h0C40, 16'h0000, 1'b1, 1'b0, 4, 16'hD000);  // reset mid-fill
        do_hit(16'h0C40, 16'hC300, 2'b10);                       // back in IDLE after reset
        repeat (2) step();

        check("q_addr_left", q_addr.size(), 0);
        check("q_data_left", q_data.size(), 0);
        check("q_meta_left", q_meta.size(), 0);
        check("q_hit_left", q_hit.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
